// File: rtl/rsa_keygen_ctrl_if.sv
// Key-load and modular-inverse handshake bundle for rsa_keygen_ctrl.
// The slave modport is the controller's view; master is the environment
// (key loader plus inverse engine).
interface rsa_keygen_ctrl_if #(
    parameter int WIDTH = 64
);
    localparam int H = WIDTH / 2;

    // key-load side
    logic             start;
    logic [H-1:0]     p;
    logic [H-1:0]     q;
    logic [WIDTH-1:0] e;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] phi;
    logic [WIDTH-1:0] d;

    // modular-inverse engine side
    logic             inv_go;
    logic [WIDTH-1:0] inv_e;
    logic [WIDTH-1:0] inv_phi;
    logic [WIDTH-1:0] inv_result;
    logic             inv_done;

    modport slave (
        input  start, p, q, e, inv_result, inv_done,
        output busy, done, error, err_code, n, phi, d, inv_go, inv_e, inv_phi
    );

    modport master (
        output start, p, q, e, inv_result, inv_done,
        input  busy, done, error, err_code, n, phi, d, inv_go, inv_e, inv_phi
    );
endinterface

// File: rtl/rsa_keygen_ctrl.sv
// RSA key derivation sequencer: validates p, q, e, computes n = p*q and
// phi = (p-1)(q-1) on a shift-add multiplier, then drives the external
// modular-inverse engine to obtain d = e^-1 mod phi.
module rsa_keygen_ctrl #(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    rsa_keygen_ctrl_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int IW = $clog2(H + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL_N,
        MUL_PHI,
        INV_GO,
        INV_SETTLE,
        INV_WAIT,
        FINISH
    } state_t;

    state_t           state;
    logic [H-1:0]     p_r;
    logic [H-1:0]     q_r;
    logic [WIDTH-1:0] e_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [H-1:0]     mplier;
    logic [IW-1:0]    iter;
    logic [TW-1:0]    tcnt;

    logic [WIDTH-1:0] acc_next;
    logic             bad_input;
    logic             last_iter;

    // Multiplier step and input validation, shared by both multiply phases
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
        bad_input = (p_r < H'(2)) || (q_r < H'(2)) || (p_r == q_r) ||
                    (e_r < WIDTH'(3)) || !e_r[0];
        last_iter = (iter == IW'(H - 1));
    end

    // Sequencer FSM with registered outputs; done and inv_go are single-cycle
    // pulses raised on entry to FINISH and INV_GO respectively
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            p_r          <= '0;
            q_r          <= '0;
            e_r          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            iter         <= '0;
            tcnt         <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            bus.err_code <= '0;
            bus.n        <= '0;
            bus.phi      <= '0;
            bus.d        <= '0;
            bus.inv_go   <= 1'b0;
            bus.inv_e    <= '0;
            bus.inv_phi  <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.inv_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        p_r          <= bus.p;
                        q_r          <= bus.q;
                        e_r          <= bus.e;
                        bus.error    <= 1'b0;
                        bus.err_code <= '0;
                        bus.n        <= '0;
                        bus.phi      <= '0;
                        bus.d        <= '0;
                        bus.busy     <= 1'b1;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_input) begin
                        bus.error    <= 1'b1;
                        bus.err_code <= 2'd0;
                        bus.done     <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        acc    <= '0;
                        mcand  <= {{(WIDTH - H){1'b0}}, p_r};
                        mplier <= q_r;
                        iter   <= '0;
                        state  <= MUL_N;
                    end
                end
                MUL_N: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + 1'b1;
                    if (last_iter) begin
                        bus.n  <= acc_next;
                        acc    <= '0;
                        mcand  <= {{(WIDTH - H){1'b0}}, p_r - 1'b1};
                        mplier <= q_r - 1'b1;
                        iter   <= '0;
                        state  <= MUL_PHI;
                    end
                end
                MUL_PHI: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    iter   <= iter + 1'b1;
                    if (last_iter) begin
                        bus.phi <= acc_next;
                        if (e_r >= acc_next) begin
                            bus.error    <= 1'b1;
                            bus.err_code <= 2'd1;
                            bus.done     <= 1'b1;
                            state        <= FINISH;
                        end else begin
                            // operands and launch pulse are registered here so
                            // they are valid throughout the INV_GO cycle
                            bus.inv_go  <= 1'b1;
                            bus.inv_e   <= e_r;
                            bus.inv_phi <= acc_next;
                            tcnt        <= '0;
                            state       <= INV_GO;
                        end
                    end
                end
                INV_GO: begin
                    state <= INV_SETTLE;
                end
                INV_SETTLE: begin
                    state <= INV_WAIT;
                end
                INV_WAIT: begin
                    if (bus.inv_done) begin
                        bus.d <= bus.inv_result;
                        if (bus.inv_result == '0) begin
                            bus.error    <= 1'b1;
                            bus.err_code <= 2'd2;
                        end
                        bus.done <= 1'b1;
                        state    <= FINISH;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        bus.error    <= 1'b1;
                        bus.err_code <= 2'd3;
                        bus.d        <= '0;
                        bus.done     <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                FINISH: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
